// File: rtl/chu_video_mixer_pkg.sv
// chu_video_mixer_pkg
// Shared definitions for the video layer mixer: slot register offsets,
// CTRL bit positions, alpha width, compositing mode and alpha weighting.
package chu_video_mixer_pkg;

  localparam logic [1:0] REG_CTRL  = 2'd0;
  localparam logic [1:0] REG_ALPHA = 2'd1;
  localparam logic [1:0] REG_BG    = 2'd2;

  localparam int ALPHA_W       = 4;
  localparam int CTRL_EN_LSB   = 0;
  localparam int CTRL_MODE_BIT = 8;
  localparam int CTRL_IMM_BIT  = 15;

  typedef enum logic {
    MIX_PRIORITY = 1'b0,
    MIX_BLEND    = 1'b1
  } mix_mode_t;

  // Full-scale alpha (15) maps to weight 16 so an opaque layer fully
  // replaces the accumulator instead of leaking 1/16 of it.
  function automatic logic [ALPHA_W:0] alpha_weight(input logic [ALPHA_W-1:0] a);
    return (a == '1) ? 5'd16 : {1'b0, a};
  endfunction

endpackage

// File: rtl/chu_mixer_stage.sv
// chu_mixer_stage
// One registered compositing stage: puts one layer pixel over the incoming
// accumulator, either by replacement (priority) or per-channel alpha blend.
// Ports:
//   clk, reset  clock, synchronous active-low reset
//   acc_i       accumulator from the previous stage
//   pix_i       layer pixel, already aligned to this stage
//   en_i        layer enable travelling with the pixel
//   mode_i      compositing mode travelling with the pixel
//   alpha_i     layer alpha travelling with the pixel
//   acc_o       registered accumulator for the next stage
module chu_mixer_stage
  import chu_video_mixer_pkg::*;
#(
  parameter int            CD        = 12,
  parameter logic [CD-1:0] KEY_COLOR = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [CD-1:0]      acc_i,
  input  logic [CD-1:0]      pix_i,
  input  logic               en_i,
  input  mix_mode_t          mode_i,
  input  logic [ALPHA_W-1:0] alpha_i,
  output logic [CD-1:0]      acc_o
);

  localparam int W  = CD / 3;
  localparam int MW = W + 5;

  logic [CD-1:0]    acc_d, acc_q;
  logic [ALPHA_W:0] w;
  logic [MW-1:0]    mix;

  always_comb begin
    acc_d = acc_i;
    w     = alpha_weight(alpha_i);
    mix   = '0;
    if (en_i && (pix_i != KEY_COLOR)) begin
      if (mode_i == MIX_PRIORITY) begin
        acc_d = pix_i;
      end else begin
        for (int c = 0; c < 3; c++) begin
          // Truncating blend; w = 0 reduces to the accumulator itself.
          mix = MW'(w) * MW'(pix_i[c*W +: W])
              + MW'(5'd16 - w) * MW'(acc_i[c*W +: W]);
          acc_d[c*W +: W] = W'(mix >> 4);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/chu_video_layer_mixer_core.sv
// chu_video_layer_mixer_core
// NL-layer video compositor on a video slot. Pending configuration is
// written through the slot and copied to active at frame start (or every
// cycle while active immediate is set). Active config is sampled with the
// pixel at S0 and travels with it, so one pixel never mixes two configs.
// Ports:
//   clk, reset              clock, synchronous active-low reset
//   x, y                    pixel coordinates (alignment only, unused)
//   frame_start             commit pulse for pending configuration
//   cs, write, addr,        slot write port; addr[1:0] selects CTRL,
//   wr_data                 ALPHA, BG (3 reserved)
//   si_rgb                  NL input layers, layer i at [i*CD +: CD]
//   so_rgb                  composited pixel, NL+1 cycles after si_rgb
module chu_video_layer_mixer_core
  import chu_video_mixer_pkg::*;
#(
  parameter int            CD        = 12,
  parameter int            NL        = 4,
  parameter logic [CD-1:0] KEY_COLOR = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      x,
  input  logic [10:0]      y,
  input  logic             frame_start,
  input  logic             cs,
  input  logic             write,
  input  logic [13:0]      addr,
  input  logic [31:0]      wr_data,
  input  logic [NL*CD-1:0] si_rgb,
  output logic [CD-1:0]    so_rgb
);

  typedef struct packed {
    logic [CD-1:0]      pix;
    logic               en;
    mix_mode_t          mode;
    logic [ALPHA_W-1:0] alpha;
  } lane_t;

  logic unused_inputs;
  assign unused_inputs = ^{x, y, addr, wr_data};

  // Pending (slot-visible) and active (pipeline-visible) configuration
  logic [NL-1:0]         pend_en_q, pend_en_d, act_en_q, act_en_d;
  mix_mode_t             pend_mode_q, pend_mode_d, act_mode_q, act_mode_d;
  logic                  pend_imm_q, pend_imm_d, act_imm_q, act_imm_d;
  logic [NL*ALPHA_W-1:0] pend_alpha_q, pend_alpha_d, act_alpha_q, act_alpha_d;
  logic [CD-1:0]         pend_bg_q, pend_bg_d, act_bg_q, act_bg_d;
  logic [CD-1:0]         s0_acc_q, s0_acc_d;

  always_comb begin
    pend_en_d    = pend_en_q;
    pend_mode_d  = pend_mode_q;
    pend_imm_d   = pend_imm_q;
    pend_alpha_d = pend_alpha_q;
    pend_bg_d    = pend_bg_q;
    if (cs && write) begin
      case (addr[1:0])
        REG_CTRL: begin
          pend_en_d   = wr_data[CTRL_EN_LSB +: NL];
          pend_mode_d = mix_mode_t'(wr_data[CTRL_MODE_BIT]);
          pend_imm_d  = wr_data[CTRL_IMM_BIT];
        end
        REG_ALPHA: pend_alpha_d = wr_data[NL*ALPHA_W-1:0];
        REG_BG:    pend_bg_d    = wr_data[CD-1:0];
        default: ;
      endcase
    end
    // Commit copies the pre-write pending state, so a write landing on a
    // commit cycle waits for the next commit.
    act_en_d    = act_en_q;
    act_mode_d  = act_mode_q;
    act_imm_d   = act_imm_q;
    act_alpha_d = act_alpha_q;
    act_bg_d    = act_bg_q;
    if (frame_start || act_imm_q) begin
      act_en_d    = pend_en_q;
      act_mode_d  = pend_mode_q;
      act_imm_d   = pend_imm_q;
      act_alpha_d = pend_alpha_q;
      act_bg_d    = pend_bg_q;
    end
    s0_acc_d = act_bg_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_en_q    <= '1;
      pend_mode_q  <= MIX_PRIORITY;
      pend_imm_q   <= 1'b0;
      pend_alpha_q <= '1;
      pend_bg_q    <= '0;
      act_en_q     <= '1;
      act_mode_q   <= MIX_PRIORITY;
      act_imm_q    <= 1'b0;
      act_alpha_q  <= '1;
      act_bg_q     <= '0;
      s0_acc_q     <= '0;
    end else begin
      pend_en_q    <= pend_en_d;
      pend_mode_q  <= pend_mode_d;
      pend_imm_q   <= pend_imm_d;
      pend_alpha_q <= pend_alpha_d;
      pend_bg_q    <= pend_bg_d;
      act_en_q     <= act_en_d;
      act_mode_q   <= act_mode_d;
      act_imm_q    <= act_imm_d;
      act_alpha_q  <= act_alpha_d;
      act_bg_q     <= act_bg_d;
      s0_acc_q     <= s0_acc_d;
    end
  end

  logic [CD-1:0] acc_chain [0:NL];
  assign acc_chain[0] = s0_acc_q;

  for (genvar j = 0; j < NL; j++) begin : g_layer
    // Layer j waits j+1 cycles; its first flop samples the active config
    // on the same edge S0 samples BG, so pixel and config stay together.
    lane_t ln_q [0:j];
    lane_t ln_d [0:j];

    always_comb begin
      ln_d[0].pix   = si_rgb[j*CD +: CD];
      ln_d[0].en    = act_en_q[j];
      ln_d[0].mode  = act_mode_q;
      ln_d[0].alpha = act_alpha_q[j*ALPHA_W +: ALPHA_W];
      for (int k = 1; k <= j; k++) ln_d[k] = ln_q[k-1];
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        for (int k = 0; k <= j; k++) ln_q[k] <= '0;
      end else begin
        for (int k = 0; k <= j; k++) ln_q[k] <= ln_d[k];
      end
    end

    chu_mixer_stage #(.CD(CD), .KEY_COLOR(KEY_COLOR)) u_stage (
      .clk     (clk),
      .reset   (reset),
      .acc_i   (acc_chain[j]),
      .pix_i   (ln_q[j].pix),
      .en_i    (ln_q[j].en),
      .mode_i  (ln_q[j].mode),
      .alpha_i (ln_q[j].alpha),
      .acc_o   (acc_chain[j+1])
    );
  end

  assign so_rgb = acc_chain[NL];

endmodule

// File: tb/tb_chu_video_layer_mixer_core.sv
module tb_chu_video_layer_mixer_core;

  logic        clk = 1'b0;
  logic        reset, frame_start, cs, write;
  logic [10:0] x, y;
  logic [13:0] addr;
  logic [31:0] wr_data;
  logic [47:0] si4;
  logic [23:0] si2;
  logic [95:0] si8;
  logic [11:0] so4, so2, so8;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  chu_video_layer_mixer_core #(.CD(12), .NL(4)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .frame_start(frame_start),
    .cs(cs), .write(write), .addr(addr), .wr_data(wr_data),
    .si_rgb(si4), .so_rgb(so4));

  chu_video_layer_mixer_core #(.CD(12), .NL(2)) dut2 (
    .clk(clk), .reset(reset), .x(x), .y(y), .frame_start(frame_start),
    .cs(cs), .write(write), .addr(addr), .wr_data(wr_data),
    .si_rgb(si2), .so_rgb(so2));

  chu_video_layer_mixer_core #(.CD(12), .NL(8)) dut8 (
    .clk(clk), .reset(reset), .x(x), .y(y), .frame_start(frame_start),
    .cs(cs), .write(write), .addr(addr), .wr_data(wr_data),
    .si_rgb(si8), .so_rgb(so8));

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = {12'd0, a}; wr_data = d;
    tick();
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic commit();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    reset = 1'b0; frame_start = 1'b0; cs = 1'b0; write = 1'b0;
    x = '0; y = '0; addr = '0; wr_data = '0;
    si2 = '0; si8 = '0;
    // layers 3..0 = 000, F00, 000, 0F0
    si4 = {12'h000, 12'hF00, 12'h000, 12'h0F0};

    // Reset held 3 cycles with live input
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_hold", so4, 12'h000);
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_reset_zero", so4, 12'h000);
    end
    tick();
    chk("post_reset_first", so4, 12'hF00);

    // Priority: exact 5-cycle latency
    si4 = '0;
    tick(6);
    chk("prio_flush", so4, 12'h000);
    si4 = {12'h000, 12'hF00, 12'h000, 12'h0F0};
    tick(4);
    chk("prio_lat4", so4, 12'h000);
    tick();
    chk("prio_lat5", so4, 12'hF00);

    // Disable layer 2, commit, watch the switch NL+1 cycles later
    wr(2'd0, 32'h0000_000B);
    commit();
    tick(4);
    chk("prio_dis_old", so4, 12'hF00);
    tick();
    chk("prio_dis_new", so4, 12'h0F0);

    // Blend: layer 0 = FFF over BG, others keyed
    si4 = {12'h000, 12'h000, 12'h000, 12'hFFF};
    wr(2'd1, 32'h0000_FFF8);
    wr(2'd0, 32'h0000_010F);
    commit();
    tick(6);
    chk("blend_a8", so4, 12'h777);
    wr(2'd1, 32'h0000_FFFF);
    commit();
    tick(6);
    chk("blend_a15", so4, 12'hFFF);
    wr(2'd1, 32'h0000_FFF0);
    commit();
    tick(6);
    chk("blend_a0", so4, 12'h000);
    // w=4 over BG 840: R (60+96)>>4=9, G (60+48)>>4=6, B 60>>4=3
    wr(2'd1, 32'h0000_FFF4);
    wr(2'd2, 32'h0000_0840);
    commit();
    tick(6);
    chk("blend_a4_bg", so4, 12'h963);

    // Back to priority, opaque alphas, BG 0
    wr(2'd1, 32'h0000_FFFF);
    wr(2'd2, 32'h0000_0000);
    wr(2'd0, 32'h0000_000F);
    commit();
    si4 = '0;
    tick(6);
    chk("restore", so4, 12'h000);

    // Shadow commit: BG write is invisible until frame_start
    wr(2'd2, 32'h0000_000F);
    tick(8);
    chk("shadow_hold", so4, 12'h000);
    commit();
    tick(4);
    chk("shadow_pre", so4, 12'h000);
    tick();
    chk("shadow_post", so4, 12'h00F);

    // Write on the same cycle as frame_start is not committed
    cs = 1'b1; write = 1'b1; addr = 14'd2; wr_data = 32'h0000_00A0;
    frame_start = 1'b1;
    tick();
    cs = 1'b0; write = 1'b0; frame_start = 1'b0;
    tick(8);
    chk("simul_not_taken", so4, 12'h00F);
    commit();
    tick(4);
    chk("simul_next_pre", so4, 12'h00F);
    tick();
    chk("simul_next_post", so4, 12'h0A0);

    // Immediate mode: commit one cycle after the write
    wr(2'd0, 32'h0000_800F);
    commit();
    tick(2);
    wr(2'd2, 32'h0000_0555);
    tick(5);
    chk("imm_pre", so4, 12'h0A0);
    tick();
    chk("imm_post", so4, 12'h555);

    // Latency sweep: single-pixel marker on layer 0 at NL=2 and NL=8
    tick(10);
    si2[11:0] = 12'hABC;
    si8[11:0] = 12'hABC;
    tick();
    si2 = '0;
    si8 = '0;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) tick();
      chk($sformatf("lat_nl2_k%0d", k), so2, (k == 3) ? 12'hABC : 12'h555);
      chk($sformatf("lat_nl8_k%0d", k), so8, (k == 9) ? 12'hABC : 12'h555);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
